// File: rtl/ps2_voice_allocator_if.sv
// Bus between the PS/2 byte receiver side and the voice allocator.
// The master drives the received bytes and clear_all. The slave (the allocator)
// publishes the voice table, the event pulses and the counters.
interface ps2_voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2
);
  logic                    rx_valid;
  logic [7:0]              rx_data;
  logic                    clear_all;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [8*NUM_VOICES-1:0] voice_code;
  logic                    note_on;
  logic                    note_off;
  logic [VIDX_W-1:0]       event_voice;
  logic [VIDX_W:0]         held_count;
  logic [7:0]              drop_count;

  modport master (
    output rx_valid, rx_data, clear_all,
    input  voice_active, voice_code, note_on, note_off, event_voice,
           held_count, drop_count
  );

  modport slave (
    input  rx_valid, rx_data, clear_all,
    output voice_active, voice_code, note_on, note_off, event_voice,
           held_count, drop_count
  );
endinterface

// File: rtl/ps2_voice_allocator.sv
// PS/2 scancode parser and polyphonic voice allocator.
// The parser recognises make codes, F0 break prefixes and E0 extended prefixes.
// Held keys share NUM_VOICES tone-generator slots.
// Optional feature: define VOICE_STEAL_EN to make a key press steal the oldest
// voice when every voice is busy. Without it, such a press is dropped and counted.
module ps2_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int VIDX_W     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  ps2_voice_allocator_if.slave        vif
);

  typedef enum logic [1:0] {P_IDLE, P_EXT, P_BRK, P_EXTBRK} pstate_e;

  localparam logic [VIDX_W-1:0] RMAX = VIDX_W'(NUM_VOICES - 1);

  pstate_e state_q, state_d;
  logic    is_ctrl, make_req, brk_req;

  logic [NUM_VOICES-1:0]             active_q, active_d;
  logic [NUM_VOICES-1:0][7:0]        code_q, code_d;
  logic [NUM_VOICES-1:0][VIDX_W-1:0] rank_q, rank_d;
  logic                              on_q, on_d, off_q, off_d;
  logic [VIDX_W-1:0]                 ev_q, ev_d;
  logic [7:0]                        drop_q, drop_d;

  logic              hit, free_any, alloc_en;
  logic [VIDX_W-1:0] hit_idx, free_idx, alloc_idx;
  logic [VIDX_W:0]   held_cnt;

  // Keyboard control bytes (reset ack, resend, errors) resync the parser.
  always_comb begin
    is_ctrl = (vif.rx_data == 8'h00) || (vif.rx_data == 8'hAA) ||
              (vif.rx_data == 8'hFA) || (vif.rx_data == 8'hFE) ||
              (vif.rx_data == 8'hFF);
  end

  // Parser state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= P_IDLE;
    else       state_q <= state_d;
  end

  // Parser next-state logic. It advances only on rx_valid. clear_all and control bytes win.
  always_comb begin
    state_d = state_q;
    if (vif.clear_all) begin
      state_d = P_IDLE;
    end else if (vif.rx_valid) begin
      if (is_ctrl) begin
        state_d = P_IDLE;
      end else begin
        unique case (state_q)
          P_IDLE:   if (vif.rx_data == 8'hE0)      state_d = P_EXT;
                    else if (vif.rx_data == 8'hF0) state_d = P_BRK;
                    else                           state_d = P_IDLE;
          P_EXT:    state_d = (vif.rx_data == 8'hF0) ? P_EXTBRK : P_IDLE;
          P_BRK:    state_d = (vif.rx_data == 8'hE0) ? P_EXTBRK : P_IDLE;
          default:  state_d = P_IDLE;
        endcase
      end
    end
  end

  // Parser outputs. Extended sequences never reach the voice table.
  always_comb begin
    make_req = 1'b0;
    brk_req  = 1'b0;
    if (!vif.clear_all && vif.rx_valid && !is_ctrl) begin
      unique case (state_q)
        P_IDLE:  make_req = (vif.rx_data != 8'hE0) && (vif.rx_data != 8'hF0);
        P_BRK:   brk_req  = (vif.rx_data != 8'hE0);
        default: ;
      endcase
    end
  end

  // Look up the voice already holding this code, and the lowest-index free voice.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (active_q[v] && code_q[v] == vif.rx_data) begin
        hit     = 1'b1;
        hit_idx = VIDX_W'(v);
      end
      if (!active_q[v]) begin
        free_any = 1'b1;
        free_idx = VIDX_W'(v);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0] old_idx;
  logic [VIDX_W-1:0] old_rank;

  // Oldest voice = highest rank. The strict compare keeps the lowest index on ties.
  always_comb begin
    old_idx  = '0;
    old_rank = rank_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (rank_q[v] > old_rank) begin
        old_idx  = VIDX_W'(v);
        old_rank = rank_q[v];
      end
    end
  end
`endif

  // Voice table next state: clear, allocate/steal/drop on make, release on break.
  always_comb begin
    active_d  = active_q;
    code_d    = code_q;
    rank_d    = rank_q;
    drop_d    = drop_q;
    ev_d      = ev_q;
    on_d      = 1'b0;
    off_d     = 1'b0;
    alloc_en  = 1'b0;
    alloc_idx = free_idx;
    if (vif.clear_all) begin
      active_d = '0;
      code_d   = '0;
      rank_d   = '0;
    end else if (make_req && !hit) begin
      if (free_any) begin
        alloc_en  = 1'b1;
        alloc_idx = free_idx;
        on_d      = 1'b1;
        ev_d      = free_idx;
      end else begin
`ifdef VOICE_STEAL_EN
        alloc_en  = 1'b1;
        alloc_idx = old_idx;
        on_d      = 1'b1;
        off_d     = 1'b1;
        ev_d      = old_idx;
`else
        if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
`endif
      end
    end else if (brk_req && hit) begin
      active_d[hit_idx] = 1'b0;
      code_d[hit_idx]   = 8'h00;
      rank_d[hit_idx]   = '0;
      off_d             = 1'b1;
      ev_d              = hit_idx;
    end
    // The new voice becomes the youngest. Every other sounding voice ages by one, saturating.
    if (alloc_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VIDX_W'(v) == alloc_idx) begin
          active_d[v] = 1'b1;
          code_d[v]   = vif.rx_data;
          rank_d[v]   = '0;
        end else if (active_q[v] && rank_q[v] != RMAX) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
    end
  end

  // Voice table, pulse and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= '0;
      code_q   <= '0;
      rank_q   <= '0;
      on_q     <= 1'b0;
      off_q    <= 1'b0;
      ev_q     <= '0;
      drop_q   <= '0;
    end else begin
      active_q <= active_d;
      code_q   <= code_d;
      rank_q   <= rank_d;
      on_q     <= on_d;
      off_q    <= off_d;
      ev_q     <= ev_d;
      drop_q   <= drop_d;
    end
  end

  // Count of sounding voices, derived from the active mask.
  always_comb begin
    held_cnt = '0;
    for (int v = 0; v < NUM_VOICES; v++)
      held_cnt = held_cnt + (VIDX_W + 1)'(active_q[v]);
  end

  assign vif.voice_active = active_q;
  assign vif.voice_code   = code_q;
  assign vif.note_on      = on_q;
  assign vif.note_off     = off_q;
  assign vif.event_voice  = ev_q;
  assign vif.held_count   = held_cnt;
  assign vif.drop_count   = drop_q;

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed testbench for ps2_voice_allocator (4 voices).
// Expectations for a busy-table make follow VOICE_STEAL_EN.
module tb_ps2_voice_allocator;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_on, n_off;
  logic p_on, p_off;
  logic [1:0] p_ev;

  always #5 clk = ~clk;

  ps2_voice_allocator_if #(.NUM_VOICES(4), .VIDX_W(2)) bus();

  ps2_voice_allocator #(.NUM_VOICES(4), .VIDX_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .vif   (bus)
  );

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    @(negedge clk);
    bus.rx_valid = 1'b0;
    p_on  = bus.note_on;
    p_off = bus.note_off;
    p_ev  = bus.event_voice;
    if (p_on)  n_on++;
    if (p_off) n_off++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset         = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.clear_all = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_on  = 0;
    n_off = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.voice_active, bus.voice_code, bus.note_on, bus.note_off, bus.event_voice,
         bus.held_count, bus.drop_count} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got act=%b code=%h on=%b off=%b ev=%0d held=%0d drop=%0d required all zero",
               bus.voice_active, bus.voice_code, bus.note_on, bus.note_off, bus.event_voice,
               bus.held_count, bus.drop_count);
    end
  endtask

  task automatic test_typematic();
    do_reset();
    send(8'h1C);
    n_cmp++;
    if ({p_on, p_off, p_ev} !== {1'b1, 1'b0, 2'd0}) begin
      n_err++;
      $display("FAIL first_make_pulse: got on=%b off=%b ev=%0d required on=1 off=0 ev=0", p_on, p_off, p_ev);
    end
    send(8'h1C);
    n_cmp++;
    if ({p_on, p_off, bus.voice_active, bus.voice_code, bus.held_count} !==
        {1'b0, 1'b0, 4'b0001, 32'h0000_001C, 3'd1}) begin
      n_err++;
      $display("FAIL typematic: got on=%b off=%b act=%b code=%h held=%0d required 0 0 0001 0000001c 1",
               p_on, p_off, bus.voice_active, bus.voice_code, bus.held_count);
    end
  endtask

  task automatic test_break_realloc();
    do_reset();
    send(8'h1C); send(8'h1B); send(8'h23);
    n_cmp++;
    if (bus.voice_code !== 32'h0023_1B1C || bus.held_count !== 3'd3) begin
      n_err++;
      $display("FAIL three_makes: got code=%h held=%0d required 00231b1c 3", bus.voice_code, bus.held_count);
    end
    send(8'hF0);
    n_cmp++;
    if (p_on !== 1'b0 || p_off !== 1'b0) begin
      n_err++;
      $display("FAIL f0_prefix_silent: got on=%b off=%b required 0 0", p_on, p_off);
    end
    send(8'h1B);
    n_cmp++;
    if ({p_on, p_off, p_ev, bus.voice_active, bus.voice_code, bus.held_count} !==
        {1'b0, 1'b1, 2'd1, 4'b0101, 32'h0023_001C, 3'd2}) begin
      n_err++;
      $display("FAIL break_1b: got on=%b off=%b ev=%0d act=%b code=%h held=%0d required 0 1 1 0101 0023001c 2",
               p_on, p_off, p_ev, bus.voice_active, bus.voice_code, bus.held_count);
    end
    send(8'h2B);
    n_cmp++;
    if ({p_on, p_ev, bus.voice_code} !== {1'b1, 2'd1, 32'h0023_2B1C}) begin
      n_err++;
      $display("FAIL realloc_hole: got on=%b ev=%0d code=%h required 1 1 00232b1c", p_on, p_ev, bus.voice_code);
    end
  endtask

  task automatic test_full();
    do_reset();
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    send(8'h34);
`ifdef VOICE_STEAL_EN
    n_cmp++;
    if ({p_on, p_off, p_ev, bus.voice_code, bus.drop_count} !== {1'b1, 1'b1, 2'd0, 32'h2B23_1B34, 8'd0}) begin
      n_err++;
      $display("FAIL steal_oldest: got on=%b off=%b ev=%0d code=%h drop=%0d required 1 1 0 2b231b34 0",
               p_on, p_off, p_ev, bus.voice_code, bus.drop_count);
    end
    send(8'h3C);
    n_cmp++;
    if ({p_on, p_off, p_ev, bus.voice_code} !== {1'b1, 1'b1, 2'd1, 32'h2B23_3C34}) begin
      n_err++;
      $display("FAIL steal_second: got on=%b off=%b ev=%0d code=%h required 1 1 1 2b233c34",
               p_on, p_off, p_ev, bus.voice_code);
    end
`else
    n_cmp++;
    if ({p_on, p_off, bus.voice_code, bus.drop_count} !== {1'b0, 1'b0, 32'h2B23_1B1C, 8'd1}) begin
      n_err++;
      $display("FAIL drop_when_full: got on=%b off=%b code=%h drop=%0d required 0 0 2b231b1c 1",
               p_on, p_off, bus.voice_code, bus.drop_count);
    end
    for (int i = 0; i < 260; i++) send(8'h34);
    n_cmp++;
    if (bus.drop_count !== 8'd255 || n_on !== 4) begin
      n_err++;
      $display("FAIL drop_saturate: got drop=%0d ons=%0d required 255 4", bus.drop_count, n_on);
    end
`endif
    n_cmp++;
    if (bus.held_count !== 3'd4 || bus.voice_active !== 4'b1111) begin
      n_err++;
      $display("FAIL full_held: got held=%0d act=%b required 4 1111", bus.held_count, bus.voice_active);
    end
  endtask

  task automatic test_extended_ctrl();
    do_reset();
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hFA); send(8'hAA);
    n_cmp++;
    if (n_on !== 0 || n_off !== 0 || bus.voice_active !== 4'b0000) begin
      n_err++;
      $display("FAIL ext_ctrl_silent: got ons=%0d offs=%0d act=%b required 0 0 0000", n_on, n_off, bus.voice_active);
    end
    send(8'h1C);
    n_cmp++;
    if ({p_on, p_ev, bus.voice_code} !== {1'b1, 2'd0, 32'h0000_001C}) begin
      n_err++;
      $display("FAIL after_ext_make: got on=%b ev=%0d code=%h required 1 0 0000001c", p_on, p_ev, bus.voice_code);
    end
    send(8'hF0); send(8'hFA); send(8'h1B);
    n_cmp++;
    if ({p_on, p_off, p_ev, bus.voice_code} !== {1'b1, 1'b0, 2'd1, 32'h0000_1B1C}) begin
      n_err++;
      $display("FAIL fa_aborts_break: got on=%b off=%b ev=%0d code=%h required 1 0 1 00001b1c",
               p_on, p_off, p_ev, bus.voice_code);
    end
    send(8'hF0); send(8'h00); send(8'h1C);
    n_cmp++;
    if ({p_on, p_off, bus.voice_active} !== {1'b0, 1'b0, 4'b0011}) begin
      n_err++;
      $display("FAIL ctrl00_aborts_break: got on=%b off=%b act=%b required 0 0 0011", p_on, p_off, bus.voice_active);
    end
  endtask

  task automatic test_clear_all();
    logic c_on, c_off;
    do_reset();
    send(8'h1C); send(8'h1B); send(8'h23);
    send(8'hF0);
    @(negedge clk);
    bus.rx_valid  = 1'b1;
    bus.rx_data   = 8'h2B;
    bus.clear_all = 1'b1;
    @(negedge clk);
    bus.rx_valid  = 1'b0;
    bus.clear_all = 1'b0;
    c_on  = bus.note_on;
    c_off = bus.note_off;
    n_cmp++;
    if ({c_on, c_off, bus.voice_active, bus.voice_code, bus.held_count} !== '0) begin
      n_err++;
      $display("FAIL clear_all: got on=%b off=%b act=%b code=%h held=%0d required all zero",
               c_on, c_off, bus.voice_active, bus.voice_code, bus.held_count);
    end
    send(8'h34);
    n_cmp++;
    if ({p_on, p_off, p_ev, bus.voice_code} !== {1'b1, 1'b0, 2'd0, 32'h0000_0034}) begin
      n_err++;
      $display("FAIL clear_resets_parser: got on=%b off=%b ev=%0d code=%h required 1 0 0 00000034",
               p_on, p_off, p_ev, bus.voice_code);
    end
    send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
    @(negedge clk);
    bus.clear_all = 1'b1;
    @(negedge clk);
    bus.clear_all = 1'b0;
    n_cmp++;
`ifdef VOICE_STEAL_EN
    if (bus.drop_count !== 8'd0) begin
      n_err++;
      $display("FAIL drop_kept_on_clear: got drop=%0d required 0", bus.drop_count);
    end
`else
    if (bus.drop_count !== 8'd1) begin
      n_err++;
      $display("FAIL drop_kept_on_clear: got drop=%0d required 1", bus.drop_count);
    end
`endif
  endtask

  task automatic test_reset_mid_break();
    do_reset();
    send(8'hF0);
    do_reset();
    send(8'h1B);
    n_cmp++;
    if ({p_on, p_off, p_ev, bus.voice_active, bus.voice_code} !== {1'b1, 1'b0, 2'd0, 4'b0001, 32'h0000_001B}) begin
      n_err++;
      $display("FAIL reset_mid_break: got on=%b off=%b ev=%0d act=%b code=%h required 1 0 0 0001 0000001b",
               p_on, p_off, p_ev, bus.voice_active, bus.voice_code);
    end
    send(8'hF0); send(8'h1B);
    @(negedge clk);
    n_cmp++;
    if (bus.note_off !== 1'b0 || bus.held_count !== 3'd0) begin
      n_err++;
      $display("FAIL pulse_width: got off=%b held=%0d required 0 0", bus.note_off, bus.held_count);
    end
  endtask

  initial begin
    bus.rx_valid  = 1'b0;
    bus.rx_data   = 8'h00;
    bus.clear_all = 1'b0;
    test_reset();
    test_typematic();
    test_break_realloc();
    test_full();
    test_extended_ctrl();
    test_clear_all();
    test_reset_mid_break();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
